// File: rtl/sync_debounce_pkg.sv
// Shared helpers for the sync_debounce slice: filter counter sizing.
package sync_debounce_pkg;

    // Width of a counter that must hold values 0..debounce; never narrower than one bit.
    function automatic int cnt_width(input int debounce);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < (debounce + 32'sd1)) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_debounce_if.sv
// Pad-side raw inputs and core-side synchronised/debounced outputs of sync_debounce.
interface sync_debounce_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] d_async;
    logic [CHANNELS-1:0] d_sync;
    logic [CHANNELS-1:0] d_stable;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                changed;

    modport master (
        output d_async,
        input  d_sync, d_stable, rise, fall, changed
    );

    modport slave (
        input  d_async,
        output d_sync, d_stable, rise, fall, changed
    );
endinterface

// File: rtl/sync_debounce_ch.sv
// One input channel: ASYNC_REG synchroniser chain, stability filter and edge strobes.
module sync_debounce_ch #(
    parameter int   STAGES   = 2,
    parameter logic INIT_BIT = 1'b0,
    parameter int   DEBOUNCE = 0,
    parameter int   CNT_W    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic d_sync,
    output logic d_stable,
    output logic rise,
    output logic fall,
    output logic strobe_next
);
    localparam logic [CNT_W-1:0] DB_CNT = CNT_W'(DEBOUNCE);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             rise_r;
    logic             fall_r;

    logic             sync_s;
    logic             stable_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             rise_nxt_s;
    logic             fall_nxt_s;

    assign sync_s = chain_r[STAGES-1];

    // Pure shift chain; nothing may sit between the metastability flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= {STAGES{INIT_BIT}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d_async};
        end
    end

    // Accept a new level only after DEBOUNCE+1 consecutive differing samples.
    always_comb begin
        stable_nxt_s = stable_r;
        cnt_nxt_s    = cnt_r;
        rise_nxt_s   = 1'b0;
        fall_nxt_s   = 1'b0;
        if (sync_s == stable_r) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r == DB_CNT) begin
            stable_nxt_s = sync_s;
            cnt_nxt_s    = {CNT_W{1'b0}};
            rise_nxt_s   = sync_s;
            fall_nxt_s   = ~sync_s;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Filter state and strobes, all cleared to the reset level without a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_r <= INIT_BIT;
            cnt_r    <= {CNT_W{1'b0}};
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            stable_r <= stable_nxt_s;
            cnt_r    <= cnt_nxt_s;
            rise_r   <= rise_nxt_s;
            fall_r   <= fall_nxt_s;
        end
    end

    assign d_sync      = sync_s;
    assign d_stable    = stable_r;
    assign rise        = rise_r;
    assign fall        = fall_r;
    assign strobe_next = rise_nxt_s | fall_nxt_s;
endmodule

// File: rtl/sync_debounce.sv
// Multi-channel clock-domain entry for asynchronous inputs: synchronise, debounce, strobe.
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int                  CHANNELS = 4,
    parameter int                  STAGES   = 2,
    parameter logic [CHANNELS-1:0] INIT     = {CHANNELS{1'b0}},
    parameter int                  DEBOUNCE = 0
) (
    input logic           clk,
    input logic           rst,
    sync_debounce_if.slave bus
);
    localparam int CNT_W = cnt_width(DEBOUNCE);

    logic [CHANNELS-1:0] sync_s;
    logic [CHANNELS-1:0] stable_s;
    logic [CHANNELS-1:0] rise_s;
    logic [CHANNELS-1:0] fall_s;
    logic [CHANNELS-1:0] strobe_next_s;
    logic                changed_r;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sync_debounce_ch #(
            .STAGES   (STAGES),
            .INIT_BIT (INIT[i]),
            .DEBOUNCE (DEBOUNCE),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .d_async     (bus.d_async[i]),
            .d_sync      (sync_s[i]),
            .d_stable    (stable_s[i]),
            .rise        (rise_s[i]),
            .fall        (fall_s[i]),
            .strobe_next (strobe_next_s[i])
        );
    end

    // changed is built from next-cycle strobes so it lands in the same cycle as rise/fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed_r <= 1'b0;
        end else begin
            changed_r <= |strobe_next_s;
        end
    end

    assign bus.d_sync   = sync_s;
    assign bus.d_stable = stable_s;
    assign bus.rise     = rise_s;
    assign bus.fall     = fall_s;
    assign bus.changed  = changed_r;
endmodule

// File: tb/tb_sync_debounce.sv
// Directed and model-checked bench for sync_debounce across several parameter sets.
module tb_sync_debounce;
    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1, rst_e = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sync_debounce_if #(.CHANNELS(4)) if_a ();
    sync_debounce_if #(.CHANNELS(4)) if_b ();
    sync_debounce_if #(.CHANNELS(4)) if_c ();
    sync_debounce_if #(.CHANNELS(4)) if_d ();
    sync_debounce_if #(.CHANNELS(8)) if_e ();

    sync_debounce #(.CHANNELS(4), .STAGES(2), .INIT(4'b1010), .DEBOUNCE(0))
        dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
    sync_debounce #(.CHANNELS(4), .STAGES(3), .INIT(4'b0000), .DEBOUNCE(0))
        dut_b (.clk(clk), .rst(rst_b), .bus(if_b));
    sync_debounce #(.CHANNELS(4), .STAGES(2), .INIT(4'b0010), .DEBOUNCE(4))
        dut_c (.clk(clk), .rst(rst_c), .bus(if_c));
    sync_debounce #(.CHANNELS(4), .STAGES(2), .INIT(4'b0100), .DEBOUNCE(10))
        dut_d (.clk(clk), .rst(rst_d), .bus(if_d));
    sync_debounce #(.CHANNELS(8), .STAGES(2), .INIT(8'hA5), .DEBOUNCE(2))
        dut_e (.clk(clk), .rst(rst_e), .bus(if_e));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [16:0] got;
        if_a.d_async = 4'b0101;
        repeat (3) tick();
        got = {if_a.d_sync, if_a.d_stable, if_a.rise, if_a.fall, if_a.changed};
        checks++;
        if (got !== {4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL reset_held got %h want %h", got, {4'b1010, 4'b1010, 9'd0});
        end
        rst_a = 1'b0;
        #1;
        got = {if_a.d_sync, if_a.d_stable, if_a.rise, if_a.fall, if_a.changed};
        checks++;
        if (got !== {4'b1010, 4'b1010, 9'd0}) begin
            errors++; $display("FAIL reset_release got %h want %h", got, {4'b1010, 4'b1010, 9'd0});
        end
        #0 tick();
        tick();
        got = {if_a.d_sync, if_a.d_stable, if_a.rise, if_a.fall, if_a.changed};
        checks++;
        if (got !== {4'b0101, 4'b1010, 9'd0}) begin
            errors++; $display("FAIL reset_edge2 got %h want %h", got, {4'b0101, 4'b1010, 9'd0});
        end
        tick();
        got = {if_a.d_sync, if_a.d_stable, if_a.rise, if_a.fall, if_a.changed};
        checks++;
        if (got !== {4'b0101, 4'b0101, 4'b0101, 4'b1010, 1'b1}) begin
            errors++; $display("FAIL reset_edge3 got %h want %h", got, {4'b0101, 4'b0101, 4'b0101, 4'b1010, 1'b1});
        end
        tick();
        got = {if_a.d_sync, if_a.d_stable, if_a.rise, if_a.fall, if_a.changed};
        checks++;
        if (got !== {4'b0101, 4'b0101, 9'd0}) begin
            errors++; $display("FAIL reset_edge4 got %h want %h", got, {4'b0101, 4'b0101, 9'd0});
        end
    endtask

    task automatic test_latency();
        logic [12:0] got;
        if_b.d_async = 4'b0000;
        tick();
        rst_b = 1'b0;
        repeat (3) tick();
        if_b.d_async = 4'b0001;
        tick();
        tick();
        tick();
        got = {if_b.d_sync, if_b.d_stable, if_b.rise};
        checks++;
        if (got !== {4'b0001, 4'b0000, 4'b0000}) begin
            errors++; $display("FAIL latency_sync got %h want %h", got, {4'b0001, 8'h00});
        end
        tick();
        got = {if_b.d_stable, if_b.rise, if_b.fall, if_b.changed};
        checks++;
        if (got !== {4'b0001, 4'b0001, 4'b0000, 1'b1}) begin
            errors++; $display("FAIL latency_rise got %h want %h", got, {4'b0001, 4'b0001, 4'b0000, 1'b1});
        end
        tick();
        got = {if_b.d_stable, if_b.rise, if_b.fall, if_b.changed};
        checks++;
        if (got !== {4'b0001, 4'b0000, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL latency_rise_end got %h want %h", got, {4'b0001, 9'd0});
        end
        if_b.d_async = 4'b0000;
        repeat (3) tick();
        got = {if_b.d_stable, if_b.rise, if_b.fall, if_b.changed};
        checks++;
        if (got !== {4'b0001, 9'd0}) begin
            errors++; $display("FAIL latency_fall_early got %h want %h", got, {4'b0001, 9'd0});
        end
        tick();
        got = {if_b.d_stable, if_b.rise, if_b.fall, if_b.changed};
        checks++;
        if (got !== {4'b0000, 4'b0000, 4'b0001, 1'b1}) begin
            errors++; $display("FAIL latency_fall got %h want %h", got, {8'h00, 4'b0001, 1'b1});
        end
    endtask

    // Drives pat[i] on channel ch of dut_c before the i-th edge and records strobes after it.
    task automatic run_c(input logic [31:0] pat, input int n, input int ch,
                         output int n_r, output int n_f, output int at_r, output int at_f);
        n_r = 0; n_f = 0; at_r = -1; at_f = -1;
        for (int i = 0; i < n; i++) begin
            if_c.d_async[ch] = pat[i];
            tick();
            if (if_c.rise[ch]) begin n_r++; if (at_r < 0) at_r = i; end
            if (if_c.fall[ch]) begin n_f++; if (at_f < 0) at_f = i; end
        end
    endtask

    task automatic test_glitch();
        int n_r, n_f, at_r, at_f;
        int lens [3] = '{1, 3, 4};
        logic [31:0] pat;
        if_c.d_async = 4'b0010;
        tick();
        rst_c = 1'b0;
        repeat (4) tick();
        foreach (lens[j]) begin
            pat = 32'hFFFF_FFFF << lens[j];
            run_c(pat, lens[j] + 12, 1, n_r, n_f, at_r, at_f);
            checks++;
            if (n_r != 0 || n_f != 0 || if_c.d_stable[1] !== 1'b1) begin
                errors++;
                $display("FAIL glitch_len%0d got rise=%0d fall=%0d stable=%b want 0 0 1",
                         lens[j], n_r, n_f, if_c.d_stable[1]);
            end
        end
        pat = 32'hFFFF_FFE0;
        run_c(pat, 20, 1, n_r, n_f, at_r, at_f);
        checks++;
        if (n_f != 1 || n_r != 1 || at_f != 6 || at_r != 11) begin
            errors++;
            $display("FAIL glitch_len5 got nfall=%0d nrise=%0d fall_at=%0d rise_at=%0d want 1 1 6 11",
                     n_f, n_r, at_f, at_r);
        end
    endtask

    task automatic test_bounce();
        int n_r, n_f, at_r, at_f;
        logic [31:0] pat;
        pat = 32'hFFFF_FFF7;
        run_c(pat, 20, 0, n_r, n_f, at_r, at_f);
        checks++;
        if (n_r != 1 || n_f != 0 || at_r != 10 || if_c.d_stable[0] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_restart got nrise=%0d nfall=%0d rise_at=%0d stable=%b want 1 0 10 1",
                     n_r, n_f, at_r, if_c.d_stable[0]);
        end
    endtask

    task automatic test_reset_mid_count();
        logic [16:0] got;
        int n_r, at_r;
        if_d.d_async = 4'b0100;
        tick();
        rst_d = 1'b0;
        repeat (3) tick();
        if_d.d_async = 4'b0101;
        repeat (9) tick();
        checks++;
        if (if_d.d_stable !== 4'b0100 || if_d.d_sync !== 4'b0101) begin
            errors++; $display("FAIL midcount_pending got sync=%b stable=%b want 0101 0100",
                               if_d.d_sync, if_d.d_stable);
        end
        #2 rst_d = 1'b1;
        #1;
        got = {if_d.d_sync, if_d.d_stable, if_d.rise, if_d.fall, if_d.changed};
        checks++;
        if (got !== {4'b0100, 4'b0100, 9'd0}) begin
            errors++; $display("FAIL midcount_async_rst got %h want %h", got, {4'b0100, 4'b0100, 9'd0});
        end
        tick();
        tick();
        rst_d = 1'b0;
        n_r = 0; at_r = -1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (if_d.rise[0]) begin n_r++; if (at_r < 0) at_r = i; end
        end
        checks++;
        if (n_r != 1 || at_r != 13) begin
            errors++; $display("FAIL midcount_full_run got nrise=%0d rise_at=%0d want 1 13", n_r, at_r);
        end
    endtask

    task automatic test_random();
        logic [7:0] din, m_s0, m_s1, m_st, m_r, m_f, nr, nf;
        logic       m_ch;
        logic [40:0] got, want;
        int m_cnt [8];
        int strobes;
        din = 8'hA5; m_s0 = 8'hA5; m_s1 = 8'hA5; m_st = 8'hA5;
        m_r = 8'h00; m_f = 8'h00; m_ch = 1'b0; strobes = 0;
        foreach (m_cnt[c]) m_cnt[c] = 0;
        if_e.d_async = din;
        tick();
        rst_e = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < 8; c++) begin
                if ($urandom_range(0, 3) == 0) din[c] = ~din[c];
            end
            if_e.d_async = din;
            tick();
            nr = 8'h00; nf = 8'h00;
            for (int c = 0; c < 8; c++) begin
                if (m_s1[c] == m_st[c]) begin
                    m_cnt[c] = 0;
                end else if (m_cnt[c] == 2) begin
                    m_st[c] = m_s1[c]; m_cnt[c] = 0;
                    nr[c] = m_s1[c]; nf[c] = ~m_s1[c];
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
            m_s1 = m_s0; m_s0 = din;
            m_r = nr; m_f = nf; m_ch = |(nr | nf);
            if (m_ch) strobes++;
            got  = {if_e.d_sync, if_e.d_stable, if_e.rise, if_e.fall, if_e.changed};
            want = {m_s1, m_st, m_r, m_f, m_ch};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL random_cycle%0d got %h want %h", cyc, got, want);
            end
        end
        checks++;
        if (strobes < 10) begin
            errors++; $display("FAIL random_activity got %0d strobe cycles want >= 10", strobes);
        end
    endtask

    initial begin
        if_a.d_async = 4'b0101;
        if_b.d_async = 4'b0000;
        if_c.d_async = 4'b0010;
        if_d.d_async = 4'b0100;
        if_e.d_async = 8'hA5;
        test_reset();
        test_latency();
        test_glitch();
        test_bounce();
        test_reset_mid_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
